// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master:
// FSM state encoding and response status codes.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_ERR     = 2'd1;
    localparam logic [1:0] RSP_RTY_EXH = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone master driven by a
// valid/ready command stream, with retry and timeout handling.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int WB_BUS_WIDTH   = 16,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3,
    localparam int WB_SEL        = WB_BUS_WIDTH / 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_reset_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [WB_BUS_WIDTH-1:0]  cmd_data_i,
    input  logic [WB_SEL-1:0]        cmd_sel_i,
    input  logic                     cmd_lock_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WB_BUS_WIDTH-1:0]  rsp_data_o,
    output logic [1:0]               rsp_status_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_BUS_WIDTH-1:0]  wb_data_o,
    output logic [WB_SEL-1:0]        wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_lock_o,
    input  logic [WB_BUS_WIDTH-1:0]  wb_data_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_rty_i,
    input  logic                     wb_stall_i
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RTY_LIM  = 4'(RETRY_MAX);

    state_t                  state;
    logic [7:0]              timer;
    logic [3:0]              retry_cnt;
    logic                    gap;
    logic                    lock_q;

    logic                    done;
    logic                    retry;
    logic                    tmo;
    logic [1:0]              done_status;
    logic [WB_BUS_WIDTH-1:0] done_data;

    // Decide whether this cycle ends the transaction, and how.
    always_comb begin
        done        = 1'b0;
        retry       = 1'b0;
        done_status = RSP_OK;
        done_data   = '0;
        tmo         = (timer == TMO_LAST);
        if (state == S_WAIT) begin
            if (wb_err_i) begin
                done        = 1'b1;
                done_status = RSP_ERR;
            end else if (wb_rty_i) begin
                if (retry_cnt < RTY_LIM) begin
                    retry = 1'b1;
                end else begin
                    done        = 1'b1;
                    done_status = RSP_RTY_EXH;
                end
            end else if (wb_ack_i) begin
                done        = 1'b1;
                done_status = RSP_OK;
                done_data   = wb_we_o ? '0 : wb_data_i;
            end else if (tmo) begin
                done        = 1'b1;
                done_status = RSP_TIMEOUT;
            end
        end else if (state == S_REQ && !gap && tmo) begin
            done        = 1'b1;
            done_status = RSP_TIMEOUT;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            state        <= S_IDLE;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_status_o <= RSP_OK;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_lock_o    <= 1'b0;
            timer        <= '0;
            retry_cnt    <= '0;
            gap          <= 1'b0;
            lock_q       <= 1'b0;
        end else if (done) begin
            state        <= S_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= done_status;
            rsp_data_o   <= done_data;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_lock_o    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        state       <= S_REQ;
                        cmd_ready_o <= 1'b0;
                        wb_addr_o   <= cmd_addr_i;
                        wb_data_o   <= cmd_data_i;
                        wb_sel_o    <= cmd_sel_i;
                        wb_we_o     <= cmd_we_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        wb_lock_o   <= cmd_lock_i;
                        lock_q      <= cmd_lock_i;
                        timer       <= '0;
                        retry_cnt   <= '0;
                        gap         <= 1'b0;
                    end
                end
                S_REQ: begin
                    // The gap cycle keeps cyc low once before re-requesting.
                    if (gap) begin
                        gap       <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_lock_o <= lock_q;
                    end else begin
                        timer <= timer + 8'd1;
                        if (!wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (retry) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        timer     <= '0;
                        gap       <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_lock_o <= 1'b0;
                        state     <= S_REQ;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed, table-driven bench for wb_cmd_master with a
// scripted Wishbone slave (stall, retry, ack/err, silence).
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic [1:0]  cmd_sel = '0;
    logic        cmd_lock = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [31:0] wb_addr;
    logic [15:0] wb_dout;
    logic [1:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_lock;
    logic [15:0] wb_din = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wb_rty = 1'b0;
    logic        wb_stall = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .WB_BUS_WIDTH(16),
        .WB_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(8),
        .RETRY_MAX(3)
    ) dut (
        .wb_clk_i(clk),
        .wb_reset_i(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr),
        .cmd_data_i(cmd_data),
        .cmd_sel_i(cmd_sel),
        .cmd_lock_i(cmd_lock),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .rsp_status_o(rsp_status),
        .wb_addr_o(wb_addr),
        .wb_data_o(wb_dout),
        .wb_sel_o(wb_sel),
        .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc),
        .wb_stb_o(wb_stb),
        .wb_lock_o(wb_lock),
        .wb_data_i(wb_din),
        .wb_ack_i(wb_ack),
        .wb_err_i(wb_err),
        .wb_rty_i(wb_rty),
        .wb_stall_i(wb_stall)
    );

    // term: 0 ack, 1 err, 2 err+ack, 3 silent
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
        logic        lock;
        int          stall;
        int          nrty;
        int          term;
        logic [15:0] rdata;
        logic [1:0]  e_st;
        logic [15:0] e_data;
        int          e_stb;
        int          e_cyc;
        int          e_acc;
        int          e_gap;
    } vec_t;

    vec_t vecs[9];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx, input int hold);
        int stb_n = 0, cyc_n = 0, acc = 0, gaps = 0, scnt = 0, att = 0;
        bit seen = 0;
        bit stable = 1;
        logic [15:0] d0;
        logic [1:0]  s0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        cmd_sel   = v.sel;
        cmd_lock  = v.lock;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_0000;
        cmd_data  = 16'h0BAD;
        for (int c = 0; c < 100 && !seen; c++) begin
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wb_rty   = 1'b0;
            wb_stall = 1'b0;
            wb_din   = 16'($urandom);
            if (rsp_valid) begin
                seen = 1;
            end else begin
                if (wb_cyc) cyc_n++;
                else gaps++;
                if (wb_cyc && wb_stb) begin
                    stb_n++;
                    if (wb_addr !== v.addr || wb_we !== v.we ||
                        wb_sel !== v.sel || wb_lock !== v.lock ||
                        (v.we && wb_dout !== v.data))
                        stable = 0;
                    if (scnt < v.stall) begin
                        wb_stall = 1'b1;
                        scnt++;
                    end else begin
                        acc++;
                        scnt = 0;
                    end
                end else if (wb_cyc) begin
                    if (att < v.nrty) begin
                        wb_rty = 1'b1;
                        att++;
                    end else begin
                        case (v.term)
                            0: begin wb_ack = 1'b1; wb_din = v.rdata; end
                            1: wb_err = 1'b1;
                            2: begin wb_err = 1'b1; wb_ack = 1'b1; wb_din = v.rdata; end
                            default: ;
                        endcase
                    end
                end
                @(negedge clk);
            end
        end
        if (!seen) begin
            chk($sformatf("v%0d rsp_valid within budget", idx), 0, 1);
            return;
        end
        chk($sformatf("v%0d status", idx), rsp_status, v.e_st);
        chk($sformatf("v%0d rsp_data", idx), rsp_data, v.e_data);
        chk($sformatf("v%0d stb cycles", idx), stb_n, v.e_stb);
        chk($sformatf("v%0d cyc cycles", idx), cyc_n, v.e_cyc);
        chk($sformatf("v%0d accepted", idx), acc, v.e_acc);
        chk($sformatf("v%0d cyc gaps", idx), gaps, v.e_gap);
        chk($sformatf("v%0d req stable", idx), stable, 1);
        chk($sformatf("v%0d cmd_ready in resp", idx), cmd_ready, 0);
        d0 = rsp_data;
        s0 = rsp_status;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold%0d valid", idx, h), rsp_valid, 1);
            chk($sformatf("v%0d hold%0d data", idx, h), rsp_data, d0);
            chk($sformatf("v%0d hold%0d status", idx, h), rsp_status, s0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid drop", idx), rsp_valid, 0);
        chk($sformatf("v%0d cmd_ready back", idx), cmd_ready, 1);
        chk($sformatf("v%0d bus idle", idx), {wb_cyc, wb_stb, wb_lock}, 0);
    endtask

    initial begin
        int bad_idle;
        //        we    addr          data      sel    lk  st nr tm rdata     est  edata     stb cyc acc gap
        vecs[0] = '{1'b1, 32'h0000_00A0, 16'h1234, 2'b11, 1'b0, 0, 0, 0, 16'hFFFF, 2'd0, 16'h0000, 1, 2, 1, 0};
        vecs[1] = '{1'b0, 32'h0000_1000, 16'h0000, 2'b11, 1'b0, 3, 0, 0, 16'hBEEF, 2'd0, 16'hBEEF, 4, 5, 1, 0};
        vecs[2] = '{1'b0, 32'h0000_2002, 16'h0000, 2'b01, 1'b0, 0, 2, 0, 16'h5A5A, 2'd0, 16'h5A5A, 3, 6, 3, 2};
        vecs[3] = '{1'b1, 32'h0000_3000, 16'hCAFE, 2'b10, 1'b1, 0, 4, 0, 16'h9999, 2'd2, 16'h0000, 4, 8, 4, 3};
        vecs[4] = '{1'b0, 32'h0000_4000, 16'h0000, 2'b11, 1'b0, 0, 0, 3, 16'h4444, 2'd3, 16'h0000, 1, 8, 1, 0};
        vecs[5] = '{1'b0, 32'h0000_5000, 16'h0000, 2'b11, 1'b0, 0, 0, 2, 16'h1111, 2'd1, 16'h0000, 1, 2, 1, 0};
        vecs[6] = '{1'b1, 32'h0000_6000, 16'h0F0F, 2'b01, 1'b1, 0, 0, 1, 16'h2222, 2'd1, 16'h0000, 1, 2, 1, 0};
        vecs[7] = '{1'b0, 32'h0000_7000, 16'h0000, 2'b11, 1'b0, 10, 0, 0, 16'h3333, 2'd3, 16'h0000, 8, 8, 0, 0};
        vecs[8] = '{1'b0, 32'h0000_8000, 16'h0000, 2'b10, 1'b1, 1, 1, 0, 16'h7E57, 2'd0, 16'h7E57, 4, 6, 2, 1};

        repeat (3) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset bus", {wb_cyc, wb_stb, wb_lock, wb_we}, 0);
        chk("reset addr", wb_addr, 0);
        chk("reset rsp", {rsp_valid, rsp_status, rsp_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Terminations while idle must be ignored.
        wb_ack = 1'b1;
        wb_err = 1'b1;
        wb_rty = 1'b1;
        repeat (2) @(negedge clk);
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_rty = 1'b0;
        chk("idle ignores term", {rsp_valid, wb_cyc}, 0);
        chk("idle cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i, 0);

        // Response held while the consumer stalls.
        run_txn(vecs[5], 15, 5);

        // Reset in WAIT abandons the transaction.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h0000_00C0;
        cmd_data  = 16'hA5A5;
        cmd_sel   = 2'b11;
        cmd_lock  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset in wait", {wb_cyc, wb_stb}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset bus", {wb_cyc, wb_stb, wb_lock, wb_we}, 0);
        chk("async reset addr", wb_addr, 0);
        chk("async reset rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad_idle = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready || wb_cyc) bad_idle++;
        end
        chk("post-reset idle", bad_idle, 0);

        run_txn(vecs[0], 20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter WB_BUS_WIDTH, default 16, data bus width; WB_SEL = WB_BUS_WIDTH/8 (local).
REQ-002 Parameter WB_ADDR_WIDTH, default 32, address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles per attempt before abort (1..255).
REQ-004 Parameter RETRY_MAX, default 3, retries allowed after wb_rty_i (0..15).
REQ-005 Ports:
  wb_clk_i  in  1  sole clock, rising edge.
  wb_reset_i  in  1  reset, asynchronous, active-low.
  cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
  cmd_we_i  in  1  1=write, 0=read.
  cmd_addr_i  in  WB_ADDR_WIDTH  target address.
  cmd_data_i  in  WB_BUS_WIDTH  write data.
  cmd_sel_i  in  WB_SEL  byte enables.
  cmd_lock_i  in  1  request uninterruptible cycle.
  rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
  rsp_data_o  out  WB_BUS_WIDTH  read data (0 for writes).
  rsp_status_o  out  2  0 OK, 1 ERR, 2 RTY_EXHAUSTED, 3 TIMEOUT.
  wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_lock_o  out  bus request.
  wb_data_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  bus response.

Function
REQ-006 FSM states: IDLE, REQ, WAIT, RESP; single outstanding transaction, pipelined Wishbone.
REQ-007 IDLE: cmd_ready_o=1, bus idle; on cmd_valid_i at edge, register we/addr/data/sel/lock, clear retry and timer counters, go REQ.
REQ-008 REQ: wb_cyc_o=wb_stb_o=1, wb_lock_o=captured lock; edge with wb_stall_i=0 accepts request, go WAIT; wb_stb_o held and addr/data/sel/we stable while stalled.
REQ-009 WAIT: wb_cyc_o=1, wb_stb_o=0; termination inputs sampled only here, ignored in IDLE/REQ/RESP.
REQ-010 Termination priority err > rty > ack when asserted same cycle.
REQ-011 wb_ack_i: status OK; on read, rsp_data_o <= wb_data_i that cycle; go RESP.
REQ-012 wb_err_i: status ERR, rsp_data_o=0, go RESP.
REQ-013 wb_rty_i: if retry count < RETRY_MAX, increment, clear timer, drop cyc for exactly one cycle, re-enter REQ; else status RTY_EXHAUSTED, go RESP.
REQ-014 Timer counts every cycle in REQ/WAIT per attempt; at TIMEOUT_CYCLES with no termination: status TIMEOUT, rsp_data_o=0, go RESP.
REQ-015 RESP: wb_cyc_o=wb_stb_o=wb_lock_o=0, rsp_valid_o=1 held with stable data/status until rsp_ready_i at edge, then IDLE; cmd_ready_o=0 outside IDLE.
REQ-016 Back-to-back: new command accepted earliest the cycle after response handshake; throughput 1 transaction per 4 cycles minimum.

Reset
REQ-017 wb_reset_i low asynchronously forces IDLE; all bus outputs, rsp_valid_o, rsp_data_o, rsp_status_o, counters =0; cmd_ready_o=1; mid-transaction reset abandons it with no response.

Structure
REQ-018 Package wb_cmd_master_pkg holds FSM state encoding and rsp_status codes.
REQ-019 No sub-module; timer and retry counter inline.

Verification
REQ-020 Write addr 0x000000A0 data 0x1234 sel 2'b11, slave ack 1 cycle after accept -> stb 1 cycle, cyc 2 cycles, rsp status 0, data 0.
REQ-021 Read with wb_stall_i high 3 cycles, ack returns 0xBEEF -> stb 4 cycles, signals stable, rsp_data 0xBEEF, status 0.
REQ-022 RETRY_MAX=3: rty x2 then ack -> 3 accepted requests, 1-cycle cyc gaps, status 0; rty x4 -> status 2.
REQ-023 TIMEOUT_CYCLES=8, no termination -> cyc drops after 8 cycles, status 3.
REQ-024 err and ack same cycle -> status 1; rsp_ready_i low 5 cycles -> rsp held stable.
REQ-025 wb_reset_i low mid-WAIT -> outputs zero immediately, no rsp_valid_o, cmd_ready_o=1 after release.
